muldiv_hilo: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the mono-cycle MIPS core.
- Sits directly downstream of the register file. OperandA is fed from ReadData1 (rs) and OperandB from ReadData2 (rt).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- Exposes HI/LO continuously for MFHI/MFLO; Busy is used by control to stall the PC.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_datapath.sv | 105 ++++++++++
 rtl/muldiv_hilo.sv | 112 +++++++++++
 tb/tb_muldiv_hilo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg: shared op/state encodings for the MIPS HI/LO multiply-divide unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_datapath.sv
// ============================================================================
// muldiv_datapath: magnitude shift-add / restoring divide core with sign fix-up
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;

    logic               sgn_a, sgn_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               div_zero;

    assign sgn_a = ~op_i[0] & a_i[WIDTH-1];
    assign sgn_b = ~op_i[0] & b_i[WIDTH-1];

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
    // Partial remainder plus next dividend bit needs one extra bit before the trial subtract.
    assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff    = rem_sh - {1'b0, bmag_q};

    always_comb begin
        acc_d     = acc_q;
        bmag_d    = bmag_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (load_i) begin
            acc_d     = {{WIDTH{1'b0}}, (sgn_a ? -a_i : a_i)};
            bmag_d    = sgn_b ? -b_i : b_i;
            a_d       = a_i;
            is_div_d  = op_i[1];
            neg_res_d = sgn_a ^ sgn_b;
            neg_rem_d = sgn_a;
        end else if (step_i) begin
            if (is_div_q) begin
                acc_d = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~diff[WIDTH]};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            bmag_q    <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            bmag_q    <= bmag_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign prod     = neg_res_q ? -acc_q : acc_q;
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];
    assign div_zero = (bmag_q == '0);

    always_comb begin
        hi_o = prod[2*WIDTH-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
        if (is_div_q) begin
            // Divide by zero reports the raw dividend, not the magnitude the core used.
            hi_o = div_zero  ? a_q        : (neg_rem_q ? -rem : rem);
            lo_o = div_zero  ? '1         : (neg_res_q ? -quo : quo);
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_hilo.sv
// ============================================================================
// muldiv_hilo: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(ITER);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               load, step;
    logic [WIDTH-1:0]   res_hi, res_lo;

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .step_i (step),
        .op_i   (op_i[1:0]),
        .a_i    (operand_a_i),
        .b_i    (operand_b_i),
        .hi_o   (res_hi),
        .lo_o   (res_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            load    = 1'b1;
                            cnt_d   = '0;
                            state_d = S_CALC;
                        end
                        OP_MTHI: hi_d = operand_a_i;
                        OP_MTLO: lo_d = operand_a_i;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
// ============================================================================
// tb_muldiv_hilo: randomized + directed check of muldiv_hilo against a
// cycle-level arithmetic model of HI/LO, Busy and Done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_hilo;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    always #5 clk = ~clk;

    muldiv_hilo #(
        .WIDTH (W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .op_i        (op),
        .operand_a_i (a),
        .operand_b_i (b),
        .busy_o      (busy),
        .done_o      (done),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result {HI,LO} straight from the MIPS arithmetic rules.
    function automatic logic [2*W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] x,
                                                  input logic [W-1:0] y);
        logic signed [W-1:0] sx, sy, q, r;
        longint              sp;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin
                sp = longint'(sx) * longint'(sy);
                return sp;
            end
            3'd1: return {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    logic [W-1:0]   m_hi = '0, m_lo = '0;
    logic [2*W-1:0] m_res = '0;
    int             m_pend = 0;
    bit             m_done = 1'b0;
    bit             chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_pend = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_done = 1'b1;
                end
            end else if (start) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        m_res  = ref_result(op, a, b);
                        m_pend = W + 1;
                    end
                    3'd4: m_hi = a;
                    3'd5: m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, (m_pend != 0)});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (done) return;
            @(negedge clk);
        end
        vectors++;
        miscompares++;
        $display("FAIL done_timeout: got no Done pulse required within 60 cycles");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Abort a divide partway through the iterations.
        issue(3'd2, 32'hFFFF_FF9C, 32'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        issue(3'd1, 32'd3, 32'd5);            wait_done();
        chk("multu3x5_lo", lo, 32'd15);       chk("multu3x5_hi", hi, 32'd0);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        chk("multu_max_hi", hi, 32'hFFFF_FFFE); chk("multu_max_lo", lo, 32'h1);
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);    wait_done();
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF); chk("mult_neg_lo", lo, 32'hFFFF_FFEB);
        issue(3'd0, 32'h8000_0000, 32'h8000_0000); wait_done();
        chk("mult_min_hi", hi, 32'h4000_0000); chk("mult_min_lo", lo, 32'h0);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);    wait_done();
        chk("div_neg_lo", lo, 32'hFFFF_FFFD); chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd0);            wait_done();
        chk("divu_zero_lo", lo, 32'hFFFF_FFFF); chk("divu_zero_hi", hi, 32'd7);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        chk("div_ovf_lo", lo, 32'h8000_0000); chk("div_ovf_hi", hi, 32'd0);

        // MTHI while busy must be dropped.
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        repeat (3) @(negedge clk);
        op = 3'd4; a = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("mthi_busy_hi", hi, 32'hFFFF_FFFF); chk("mthi_busy_lo", lo, 32'hFFFF_FFFA);

        issue(3'd5, 32'h0000_CAFE, 32'd0);
        chk("mtlo_lo", lo, 32'h0000_CAFE);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);
        chk("mtlo_done", {31'b0, done}, 32'd0);

        // Start issued in the Done cycle.
        issue(3'd1, 32'd1, 32'd1);            wait_done();
        issue(3'd3, 32'd100, 32'd9);          wait_done();
        chk("b2b_divu_lo", lo, 32'd11);       chk("b2b_divu_hi", hi, 32'd1);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]   ro;
            logic [W-1:0] rx, ry;
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 15)) | (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : 32'd0);
                default: ry = 32'($urandom);
            endcase
            issue(ro, rx, ry);
            if (ro < 3'd4) wait_done();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
